// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel PWM block.
package pwm_pkg;
  localparam int PWM_CNT_W      = 10;
  localparam int PWM_DUTY_W     = 10;
  localparam int PWM_DEF_PERIOD = 606;

  typedef logic [PWM_CNT_W-1:0]  cnt_t;
  typedef logic [PWM_DUTY_W-1:0] duty_t;

  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/pwm_multi_ch_if.sv
// Duty-write port: master presents channel/duty until ready, slave pulses err a cycle after a bad channel is accepted.
interface pwm_multi_ch_if import pwm_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DUTY_W = PWM_DUTY_W
);
  localparam int CH_W = ch_idx_w(NUM_CH);

  logic              wr_valid;
  logic              wr_ready;
  logic [CH_W-1:0]   wr_ch;
  logic [DUTY_W-1:0] wr_duty;
  logic              wr_err;

  modport master (output wr_valid, wr_ch, wr_duty, input wr_ready, wr_err);
  modport slave  (input wr_valid, wr_ch, wr_duty, output wr_ready, wr_err);
endinterface

// File: rtl/pwm_ch_cmp.sv
// One PWM channel: shadow/active duty pair and a registered compare (1-cycle latency).
// Shadow accepts writes any cycle; active copies shadow only at the boundary or while disabled.
module pwm_ch_cmp #(
  parameter int CNT_W  = 10,
  parameter int DUTY_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              bnd,
  input  logic              en,
  input  logic              wr_en_i,
  input  logic [DUTY_W-1:0] wr_duty,
  input  logic              pol,
  output logic              pwm
);
  localparam int CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;

  logic [DUTY_W-1:0] duty_sh;
  logic [DUTY_W-1:0] duty_act;
  logic [CMP_W-1:0]  cnt_x;
  logic [CMP_W-1:0]  duty_x;

  assign cnt_x  = CMP_W'(cnt);
  assign duty_x = CMP_W'(duty_act);

  // duty_act > period never falls below cnt, so 100% duty holds across the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= pol;
    end else begin
      if (wr_en_i)
        duty_sh <= wr_duty;
      if (bnd || !en)
        duty_act <= duty_sh;
      pwm <= en ? ((cnt_x < duty_x) ^ pol) : pol;
    end
  end
endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared period counter, double-buffered duties, outputs registered 1 cycle after the count.
// Write port stalls (wr_ready low) only on the boundary cycle so a write never straddles an active-register load.
module pwm_multi_ch import pwm_pkg::*; #(
  parameter int              NUM_CH     = 4,
  parameter int              CNT_W      = PWM_CNT_W,
  parameter int              DUTY_W     = PWM_DUTY_W,
  parameter int              DEF_PERIOD = PWM_DEF_PERIOD,
  parameter logic [NUM_CH-1:0] POL      = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [CNT_W-1:0]  cfg_period,
  pwm_multi_ch_if.slave     wr,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start
);
  localparam int               CH_W     = ch_idx_w(NUM_CH);
  localparam int               CHX_W    = CH_W + 1;
  localparam logic [CHX_W-1:0] NUM_CH_L = CHX_W'(NUM_CH);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  period_act;
  logic              bnd;
  logic              xfer;
  logic [CHX_W-1:0]  ch_x;
  logic [NUM_CH-1:0] wr_en;

  assign bnd         = en && (cnt == period_act);
  assign wr.wr_ready = !bnd;
  assign xfer        = wr.wr_valid && wr.wr_ready;
  assign ch_x        = {1'b0, wr.wr_ch};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      period_act   <= CNT_W'(DEF_PERIOD);
      period_start <= 1'b0;
      wr.wr_err    <= 1'b0;
    end else begin
      cnt <= (en && !bnd) ? cnt + CNT_W'(1) : '0;
      // While disabled the active set tracks its sources so re-enable starts fresh.
      if (bnd || !en)
        period_act <= cfg_period;
      period_start <= en && (cnt == '0);
      wr.wr_err    <= xfer && (ch_x >= NUM_CH_L);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CHX_W-1:0] IDX = CHX_W'(i);

    assign wr_en[i] = xfer && (ch_x == IDX);

    pwm_ch_cmp #(
      .CNT_W  (CNT_W),
      .DUTY_W (DUTY_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .cnt     (cnt),
      .bnd     (bnd),
      .en      (en),
      .wr_en_i (wr_en[i]),
      .wr_duty (wr.wr_duty),
      .pol     (POL[i]),
      .pwm     (pwm_out[i])
    );
  end
endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench for pwm_multi_ch: main 4-ch build, a 3-ch build for bad-channel writes, a POL=0101 build for enable/reset.
module tb_pwm_multi_ch;
  import pwm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_ab, rst_c;
  logic en_a, en_b, en_c;
  cnt_t cfg_a, cfg_b, cfg_c;
  logic [3:0] pwm_a, pwm_c;
  logic [2:0] pwm_b;
  logic ps_a, ps_b, ps_c;

  pwm_multi_ch_if #(.NUM_CH(4), .DUTY_W(PWM_DUTY_W)) ifa();
  pwm_multi_ch_if #(.NUM_CH(3), .DUTY_W(PWM_DUTY_W)) ifb();
  pwm_multi_ch_if #(.NUM_CH(4), .DUTY_W(PWM_DUTY_W)) ifc();

  pwm_multi_ch #(.NUM_CH(4), .CNT_W(PWM_CNT_W), .DUTY_W(PWM_DUTY_W),
                 .DEF_PERIOD(PWM_DEF_PERIOD), .POL(4'b0000)) dut_a (
    .clk(clk), .rst(rst_ab), .en(en_a), .cfg_period(cfg_a), .wr(ifa),
    .pwm_out(pwm_a), .period_start(ps_a));

  pwm_multi_ch #(.NUM_CH(3), .CNT_W(PWM_CNT_W), .DUTY_W(PWM_DUTY_W),
                 .DEF_PERIOD(PWM_DEF_PERIOD), .POL(3'b000)) dut_b (
    .clk(clk), .rst(rst_ab), .en(en_b), .cfg_period(cfg_b), .wr(ifb),
    .pwm_out(pwm_b), .period_start(ps_b));

  pwm_multi_ch #(.NUM_CH(4), .CNT_W(PWM_CNT_W), .DUTY_W(PWM_DUTY_W),
                 .DEF_PERIOD(PWM_DEF_PERIOD), .POL(4'b0101)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .cfg_period(cfg_c), .wr(ifc),
    .pwm_out(pwm_c), .period_start(ps_c));

  typedef struct {
    int ch;
    int duty;
    int hi_long;   // high cycles per 607-cycle period
    int hi_short;  // high cycles per 10-cycle period
  } vec_t;

  vec_t tbl[4];
  int total = 0;
  int bad   = 0;
  int hi[4];
  int ps_cnt, ps_last;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ps_of(input int w);
    return (w == 0) ? ps_a : (w == 1) ? ps_b : ps_c;
  endfunction

  function automatic logic rdy_of(input int w);
    return (w == 0) ? ifa.wr_ready : (w == 1) ? ifb.wr_ready : ifc.wr_ready;
  endfunction

  task automatic set_wr(input int w, input logic v, input int ch, input int duty);
    case (w)
      0: begin ifa.wr_valid = v; ifa.wr_ch = 2'(ch); ifa.wr_duty = duty_t'(duty); end
      1: begin ifb.wr_valid = v; ifb.wr_ch = 2'(ch); ifb.wr_duty = duty_t'(duty); end
      default: begin ifc.wr_valid = v; ifc.wr_ch = 2'(ch); ifc.wr_duty = duty_t'(duty); end
    endcase
  endtask

  // Holds the request until ready, then clocks the accepting edge.
  task automatic do_write(input int w, input int ch, input int duty, output int stalls);
    stalls = 0;
    set_wr(w, 1'b1, ch, duty);
    while (!rdy_of(w) && stalls < 8) begin
      step();
      stalls++;
    end
    step();
    set_wr(w, 1'b0, 0, 0);
  endtask

  task automatic wait_ps(input int w, input int limit, input string name);
    int n = 0;
    while (!ps_of(w) && n < limit) begin
      step();
      n++;
    end
    chk(name, int'(ps_of(w)), 1);
  endtask

  task automatic measure(input int w, input int n);
    logic [3:0] p;
    logic s;
    for (int c = 0; c < 4; c++) hi[c] = 0;
    ps_cnt  = 0;
    ps_last = -1;
    for (int j = 0; j < n; j++) begin
      case (w)
        0: begin p = pwm_a; s = ps_a; end
        1: begin p = {1'b0, pwm_b}; s = ps_b; end
        default: begin p = pwm_c; s = ps_c; end
      endcase
      for (int c = 0; c < 4; c++) if (p[c]) hi[c]++;
      if (s) begin
        ps_cnt++;
        ps_last = j;
      end
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, n, nz, ps_n, nr_n;
    int ps_at[3];
    int nr_at[2];

    tbl[0] = '{0, 200, 200, 10};
    tbl[1] = '{1, 0,   0,   0};
    tbl[2] = '{2, 607, 607, 10};
    tbl[3] = '{3, 1,   1,   1};

    rst_ab = 1'b1; rst_c = 1'b1;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    cfg_a = cnt_t'(606); cfg_b = cnt_t'(9); cfg_c = cnt_t'(9);
    set_wr(0, 1'b0, 0, 0);
    set_wr(1, 1'b0, 0, 0);
    set_wr(2, 1'b0, 0, 0);
    repeat (2) step();

    chk("rst_pwm_a", int'(pwm_a), 0);
    chk("rst_ps_a", int'(ps_a), 0);
    chk("rst_err_a", int'(ifa.wr_err), 0);
    chk("rst_rdy_a", int'(ifa.wr_ready), 1);
    chk("rst_pwm_c", int'(pwm_c), 4'b0101);

    rst_ab = 1'b0;
    rst_c  = 1'b0;

    // Idle run: two default periods, no duties written.
    ps_n = 0; nr_n = 0; nz = 0;
    for (int i = 0; i < 3; i++) ps_at[i] = -1;
    for (int i = 0; i < 2; i++) nr_at[i] = -1;
    for (int k = 1; k <= 1214; k++) begin
      step();
      if (ps_a) begin
        if (ps_n < 3) ps_at[ps_n] = k;
        ps_n++;
      end
      if (!ifa.wr_ready) begin
        if (nr_n < 2) nr_at[nr_n] = k;
        nr_n++;
      end
      if (pwm_a != 4'b0000) nz++;
    end
    chk("idle_ps_count", ps_n, 2);
    chk("idle_ps_first", ps_at[0], 1);
    chk("idle_ps_second", ps_at[1], 608);
    chk("idle_notready_count", nr_n, 2);
    chk("idle_notready_first", nr_at[0], 606);
    chk("idle_notready_second", nr_at[1], 1213);
    chk("idle_pwm_low", nz, 0);

    // Table writes land in the shadow; current period must stay idle.
    for (int i = 0; i < 4; i++) begin
      do_write(0, tbl[i].ch, tbl[i].duty, st);
      chk($sformatf("wr_stall_ch%0d", i), st, 0);
    end
    n = 0; nz = 0;
    while (!ps_a && n < 700) begin
      if (pwm_a != 4'b0000) nz++;
      step();
      n++;
    end
    chk("wait_next_period", n, 604);
    chk("old_period_unchanged", nz, 0);
    chk("first_cycle_pattern", int'(pwm_a), 4'b1101);
    measure(0, 1214);
    chk("long_ps_count", ps_cnt, 2);
    chk("long_ps_spacing", ps_last, 607);
    for (int i = 0; i < 4; i++)
      chk($sformatf("long_hi_ch%0d", i), hi[tbl[i].ch], 2 * tbl[i].hi_long);

    // Write presented on the boundary cycle stalls one cycle.
    n = 0;
    while (ifa.wr_ready && n < 700) begin
      step();
      n++;
    end
    chk("bnd_cycle_notready", int'(ifa.wr_ready), 0);
    do_write(0, 0, 50, st);
    chk("bnd_write_stalls", st, 1);
    chk("bnd_write_ps", int'(ps_a), 1);
    measure(0, 607);
    chk("bnd_write_not_current", hi[0], 200);
    measure(0, 300);
    chk("bnd_write_next_period", hi[0], 50);

    // Shrink period mid-period: current one must still run to 606.
    cfg_a = cnt_t'(9);
    n = 0;
    while (!ps_a && n < 700) begin
      step();
      n++;
    end
    chk("period_606_finishes", n, 307);
    measure(0, 20);
    chk("short_ps_count", ps_cnt, 2);
    chk("short_ps_spacing", ps_last, 10);
    for (int i = 0; i < 4; i++)
      chk($sformatf("short_hi_ch%0d", i), hi[tbl[i].ch], 2 * tbl[i].hi_short);

    // 3-channel build: out-of-range channel.
    do_write(1, 0, 3, st);
    chk("good_write_no_err", int'(ifb.wr_err), 0);
    do_write(1, 1, 5, st);
    do_write(1, 2, 7, st);
    do_write(1, 3, 9, st);
    chk("bad_ch_err_pulse", int'(ifb.wr_err), 1);
    step();
    chk("bad_ch_err_one_cycle", int'(ifb.wr_err), 0);
    wait_ps(1, 30, "b_sync1");
    step();
    wait_ps(1, 30, "b_sync2");
    measure(1, 20);
    chk("b_hi_ch0", hi[0], 6);
    chk("b_hi_ch1", hi[1], 10);
    chk("b_hi_ch2", hi[2], 14);
    chk("b_ps_count", ps_cnt, 2);

    // POL=0101 build: enable drop, write while disabled, re-enable, async reset.
    do_write(2, 0, 3, st);
    do_write(2, 1, 3, st);
    do_write(2, 3, 20, st);
    wait_ps(2, 30, "c_sync1");
    step();
    wait_ps(2, 30, "c_sync2");
    chk("pol_ps_pattern", int'(pwm_c), 4'b1110);
    repeat (3) step();
    chk("pol_mid_pattern", int'(pwm_c), 4'b1101);
    en_c = 1'b0;
    step();
    chk("en_drop_idle", int'(pwm_c), 4'b0101);
    chk("en_drop_no_ps", int'(ps_c), 0);
    do_write(2, 2, 5, st);
    chk("disabled_write_no_stall", st, 0);
    nz = 0;
    for (int k = 0; k < 3; k++) begin
      if (pwm_c != 4'b0101 || ps_c) nz++;
      step();
    end
    chk("disabled_stays_idle", nz, 0);
    en_c = 1'b1;
    step();
    chk("en_rise_ps", int'(ps_c), 1);
    chk("en_rise_fresh_duty", int'(pwm_c), 4'b1010);
    repeat (4) step();
    #3 rst_c = 1'b1;
    #1;
    chk("async_rst_pwm", int'(pwm_c), 4'b0101);
    chk("async_rst_ps", int'(ps_c), 0);
    rst_c = 1'b0;
    step();
    chk("rst_restart_ps", int'(ps_c), 1);
    measure(2, 25);
    chk("post_rst_hi_ch0", hi[0], 25);
    chk("post_rst_hi_ch1", hi[1], 0);
    chk("post_rst_hi_ch2", hi[2], 25);
    chk("post_rst_hi_ch3", hi[3], 0);
    chk("post_rst_def_period", ps_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pwm_multi_ch.md
Name: pwm_multi_ch

Overview:
Parametrised multi-channel PWM generator for the motor/servo drive path.
- One shared period counter.
- Per-channel duty registers, double-buffered: shadow → active, transferred only at the period boundary, so every period is glitch-free.
- Duty updates arrive over a valid/ready write port from the control/decoder logic.
- Per-channel output polarity and a global enable.

Parameters:
NUM_CH, 4, number of PWM channels
CNT_W, 10, period counter width
DUTY_W, 10, duty value width, in counter ticks
DEF_PERIOD, 606, active period value after reset
POL, '0, NUM_CH-bit mask; bit i = 1 inverts pwm_out[i] (idle level = POL[i])

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  global enable
cfg_period  in  CNT_W  period value; counter runs 0..cfg_period, sampled at each boundary
wr_valid  in  1  duty write request
wr_ready  out  1  write port can accept
wr_ch  in  $clog2(NUM_CH) (min 1)  target channel
wr_duty  in  DUTY_W  new duty, in ticks
wr_err  out  1  1-cycle pulse: accepted write had wr_ch >= NUM_CH
pwm_out  out  NUM_CH  PWM outputs, registered
period_start  out  1  1-cycle pulse aligned with the first output cycle of each period

Behaviour:
- Reset values:
  - cnt = 0; period_act = DEF_PERIOD.
  - All shadow and active duties = 0.
  - pwm_out = POL (idle); period_start = 0; wr_err = 0.
  - wr_ready follows its combinational definition.
- Boundary (bnd): en = 1 && cnt == period_act.
- Counter:
  - When en = 1: cnt <= bnd ? 0 : cnt + 1.
  - When en = 0: cnt <= 0.
- Period length: period_act + 1 cycles.
  - period_act = 0 gives a 1-cycle period; it is legal.
- Active register loading:
  - On bnd, and every cycle while en = 0: period_act <= cfg_period and duty_act[i] <= duty_sh[i].
- Write handshake:
  - wr_ready = !bnd (combinational).
  - A transfer occurs when wr_valid && wr_ready.
  - On transfer with wr_ch < NUM_CH: duty_sh[wr_ch] <= wr_duty.
  - On transfer with wr_ch >= NUM_CH: no state change; wr_err pulses next cycle.
  - The master holds wr_* stable until ready. A write stalled by bnd completes the next cycle and takes effect at the following boundary.
  - A write accepted in cycle t with t < the bnd cycle takes effect in the next period. At most one period of latency.
- Output, 1-cycle registered latency:
  - pwm_out[i](k+1) = en(k) ? ((cnt(k) < duty_act[i]) ^ POL[i]) : POL[i].
  - Compare is unsigned, zero-extended to max(CNT_W, DUTY_W).
  - duty_act = 0 gives a constant inactive level.
  - duty_act > period_act gives a constant active level (100%), with no glitch at the wrap.
- period_start(k+1) = en(k) && cnt(k) == 0.
- Enable:
  - en falling: outputs return to idle on the next edge; counter clears.
  - en rising: first period starts at cnt = 0 with freshly loaded active values.
- Async reset mid-period: all state returns to reset values immediately. No partial period completes.
- Simultaneous write and bnd on the same cycle: the write is stalled, never lost or half-applied.

Decomposition:
- Package pwm_pkg:
  - PWM_CNT_W and PWM_DEF_PERIOD default constants.
  - typedef cnt_t (logic [CNT_W-1:0]) and duty_t.
  - function ch_idx_w (clog2, min 1).
- Sub-module pwm_ch_cmp:
  - Holds one channel's shadow reg, active reg, compare and output flop.
  - Instantiated NUM_CH times via generate.
  - Inputs: cnt, bnd, en, wr_en_i, wr_duty, pol.
- Top level holds: counter, period_act, handshake/decode, wr_err, period_start.

Test Plan:
- Reset with en = 1, cfg_period = 606, no writes -> all pwm_out = POL; period_start every 607 cycles; wr_ready = 0 exactly on cnt == 606.
- Write ch0 = 200, ch1 = 0, ch2 = 607, ch3 = 1 (POL = 0) -> from the next period: ch0 high 200 of 607 cycles, ch1 always low, ch2 always high with no wrap dip, ch3 one-cycle high pulse coincident with period_start.
- Assert wr_valid on the bnd cycle -> wr_ready = 0 for that cycle; accepted the next cycle; new duty visible one full period later, not in the current one.
- Change cfg_period 606 -> 9 mid-period -> current period finishes at 606; subsequent periods are 10 cycles; ch0 duty 200 becomes 100% high.
- wr_ch = NUM_CH (NUM_CH = 3 build) -> wr_err pulse one cycle after acceptance; all duties unchanged.
- POL = 4'b0101, drop en mid-period, then async rst pulse mid-period -> outputs = 0101 next edge / immediately; counter 0; on en re-rise, the first period_start pulse comes 1 cycle later.
